// File: rtl/mac_4uns_acc_pkg.sv
// Shared constants and state encoding for the 4-bit unsigned multiply-accumulate stage.
package mac_4uns_acc_pkg;

   localparam int OPW = 4;
   localparam int PRW = 8;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/mul_4x4_prod.sv
// Purely combinational 4x4 unsigned multiplier with the full 8-bit product.
module mul_4x4_prod
   import mac_4uns_acc_pkg::*;
(
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic [PRW-1:0] prod
);

   assign prod = PRW'(a) * PRW'(b);

endmodule

// File: rtl/mac_4uns_acc.sv
// Streams 4-bit operand pairs, sums CNT products per frame and hands one result
// per frame to the consumer with a valid/ready handshake.
module mac_4uns_acc
   import mac_4uns_acc_pkg::*;
#(
   parameter int CNT  = 4,
   parameter int ACCW = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [OPW-1:0]  INA,
   input  logic [OPW-1:0]  INB,
   input  logic            IVLD,
   output logic            IRDY,
   output logic [ACCW-1:0] RES,
   output logic            OVF,
   output logic            OVLD,
   input  logic            ORDY
);

   localparam int CW = $clog2(CNT + 1);
   localparam logic [CW-1:0] LAST = CW'(CNT - 1);

   state_t          state;
   logic [ACCW-1:0] acc;
   logic [CW-1:0]   count;
   logic            ovf;
   logic [PRW-1:0]  prod;
   logic [ACCW:0]   sum;

   mul_4x4_prod u_mul (
      .a    (INA),
      .b    (INB),
      .prod (prod)
   );

   // One extra bit on the adder captures the carry-out that feeds the sticky overflow flag.
   assign sum = {1'b0, acc} + {{(ACCW + 1 - PRW){1'b0}}, prod};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_ACC;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (IVLD) begin
                  acc <= sum[ACCW-1:0];
                  ovf <= ovf | sum[ACCW];
                  if (count == LAST) begin
                     count <= '0;
                     state <= ST_DONE;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               // Consuming the result reopens the input only from the next cycle on.
               if (ORDY) begin
                  state <= ST_ACC;
                  acc   <= '0;
                  ovf   <= 1'b0;
               end
            end
            default: state <= ST_ACC;
         endcase
      end
   end

   assign IRDY = (state == ST_ACC);
   assign OVLD = (state == ST_DONE);
   assign RES  = acc;
   assign OVF  = ovf;

endmodule

// File: tb/tb_mac_4uns_acc.sv
// Directed bench for mac_4uns_acc: default, CNT=2/ACCW=8 and CNT=1 instances side by side.
module tb_mac_4uns_acc;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   logic        defRst, defVld, defOrdy, defIrdy, defOvld, defOvf;
   logic [3:0]  defA, defB;
   logic [15:0] defRes;

   logic        smRst, smVld, smOrdy, smIrdy, smOvld, smOvf;
   logic [3:0]  smA, smB;
   logic [7:0]  smRes;

   logic        oneRst, oneVld, oneOrdy, oneIrdy, oneOvld, oneOvf;
   logic [3:0]  oneA, oneB;
   logic [15:0] oneRes;

   mac_4uns_acc dutDef (
      .CLK(clock), .RST(defRst), .INA(defA), .INB(defB), .IVLD(defVld), .IRDY(defIrdy),
      .RES(defRes), .OVF(defOvf), .OVLD(defOvld), .ORDY(defOrdy)
   );

   mac_4uns_acc #(.CNT(2), .ACCW(8)) dutSm (
      .CLK(clock), .RST(smRst), .INA(smA), .INB(smB), .IVLD(smVld), .IRDY(smIrdy),
      .RES(smRes), .OVF(smOvf), .OVLD(smOvld), .ORDY(smOrdy)
   );

   mac_4uns_acc #(.CNT(1)) dutOne (
      .CLK(clock), .RST(oneRst), .INA(oneA), .INB(oneB), .IVLD(oneVld), .IRDY(oneIrdy),
      .RES(oneRes), .OVF(oneOvf), .OVLD(oneOvld), .ORDY(oneOrdy)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  a;
      logic [3:0]  b;
      logic        vld;
      logic        ordy;
      logic        expIrdy;
      logic        expOvld;
      logic [15:0] expRes;
      logic        expOvf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input int a, input int b, input logic vld,
                               input logic ordy, input logic irdy, input logic ovld,
                               input int res, input logic ovf);
      vec_t v;
      v.rst = rst; v.a = 4'(a); v.b = 4'(b); v.vld = vld; v.ordy = ordy;
      v.expIrdy = irdy; v.expOvld = ovld; v.expRes = 16'(res); v.expOvf = ovf;
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives the default instance for one clock edge; outputs are sampled 1 time unit after it.
   task automatic applyStimulus(input logic rst, input int a, input int b,
                                input logic vld, input logic ordy);
      defRst = rst; defA = 4'(a); defB = 4'(b); defVld = vld; defOrdy = ordy;
      tick();
   endtask

   initial begin
      defRst = 1; defA = 0; defB = 0; defVld = 0; defOrdy = 0;
      smRst  = 1; smA  = 0; smB  = 0; smVld  = 0; smOrdy  = 0;
      oneRst = 1; oneA = 0; oneB = 0; oneVld = 0; oneOrdy = 0;
      tick();
      tick();
      smRst = 0; oneRst = 0;

      checkOutput("sm reset irdy", int'(smIrdy), 1);
      checkOutput("sm reset ovld", int'(smOvld), 0);
      checkOutput("sm reset res",  int'(smRes),  0);
      checkOutput("one reset ovld", int'(oneOvld), 0);

      // Test 1: (3,5),(15,15),(0,9),(7,2) -> 254
      vecs.push_back(mk(1,  0,  0, 0, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  3,  5, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0, 15, 15, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  0,  9, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  7,  2, 1, 1, 0, 1, 254, 0));
      vecs.push_back(mk(0,  0,  0, 0, 1, 1, 0,   0, 0));
      // Test 4: bubbles 1,0,0,1,0,1,1 with (1,4) -> 16
      vecs.push_back(mk(0,  1,  4, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  4, 0, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  4, 0, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  4, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  4, 0, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  4, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  4, 1, 1, 0, 1,  16, 0));
      // Pair offered in the consume cycle must not be taken
      vecs.push_back(mk(0, 15, 15, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  1, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  1, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  1, 1, 1, 1, 0,   0, 0));
      vecs.push_back(mk(0,  1,  1, 1, 1, 0, 1,   4, 0));
      vecs.push_back(mk(0,  0,  0, 0, 1, 1, 0,   0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, int'(vecs[i].a), int'(vecs[i].b), vecs[i].vld, vecs[i].ordy);
         checkOutput($sformatf("vec%0d irdy", i), int'(defIrdy), int'(vecs[i].expIrdy));
         checkOutput($sformatf("vec%0d ovld", i), int'(defOvld), int'(vecs[i].expOvld));
         if (vecs[i].rst || vecs[i].expOvld) begin
            checkOutput($sformatf("vec%0d res", i), int'(defRes), int'(vecs[i].expRes));
            checkOutput($sformatf("vec%0d ovf", i), int'(defOvf), int'(vecs[i].expOvf));
         end
      end

      // Test 3: (2,3)x4 with 5 cycles of backpressure and ignored IVLD pulses
      for (int i = 0; i < 4; i++) applyStimulus(0, 2, 3, 1, 0);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp%0d ovld", i), int'(defOvld), 1);
         checkOutput($sformatf("bp%0d res", i),  int'(defRes),  24);
         checkOutput($sformatf("bp%0d irdy", i), int'(defIrdy), 0);
         applyStimulus(0, 15, 15, (i % 2) == 0, 0);
      end
      checkOutput("bp end res", int'(defRes), 24);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("bp release ovld", int'(defOvld), 0);
      checkOutput("bp release irdy", int'(defIrdy), 1);

      // Test 5: reset mid-frame, then reset during DONE
      applyStimulus(0, 15, 15, 1, 1);
      applyStimulus(0, 15, 15, 1, 1);
      applyStimulus(1, 15, 15, 1, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 1, 0);
      checkOutput("rst mid ovld", int'(defOvld), 1);
      checkOutput("rst mid res",  int'(defRes),  4);
      checkOutput("rst mid ovf",  int'(defOvf),  0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("rst done ovld", int'(defOvld), 0);
      checkOutput("rst done res",  int'(defRes),  0);
      checkOutput("rst done irdy", int'(defIrdy), 1);
      defRst = 0;

      // Test 2: CNT=2, ACCW=8 wraps and sets the sticky overflow, cleared next frame
      smA = 15; smB = 15; smVld = 1; smOrdy = 0;
      tick();
      tick();
      smVld = 0;
      checkOutput("sm wrap ovld", int'(smOvld), 1);
      checkOutput("sm wrap res",  int'(smRes),  194);
      checkOutput("sm wrap ovf",  int'(smOvf),  1);
      smOrdy = 1;
      tick();
      checkOutput("sm consume ovld", int'(smOvld), 0);
      smA = 1; smB = 1; smVld = 1;
      tick();
      tick();
      smVld = 0;
      checkOutput("sm frame2 ovld", int'(smOvld), 1);
      checkOutput("sm frame2 res",  int'(smRes),  2);
      checkOutput("sm frame2 ovf",  int'(smOvf),  0);
      tick();

      // Test 6: CNT=1 exhaustive sweep, one result every two cycles
      oneOrdy = 1;
      for (int i = 0; i < 256; i++) begin
         oneA = 4'(i); oneB = 4'(i >> 4); oneVld = 1;
         tick();
         checkOutput($sformatf("one %0d*%0d ovld", i % 16, i / 16), int'(oneOvld), 1);
         checkOutput($sformatf("one %0d*%0d res", i % 16, i / 16), int'(oneRes), (i % 16) * (i / 16));
         tick();
         checkOutput($sformatf("one %0d*%0d idle", i % 16, i / 16), int'(oneIrdy), 1);
      end
      checkOutput("one ovf", int'(oneOvf), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
